// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-RAM arbiter/sequencer between instruction fetch and load/store
module mem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,

    // instruction-fetch requester
    input  logic          i_f_req,
    input  logic [AW-1:0] i_f_addr,
    output logic          o_f_ack,
    output logic [DW-1:0] o_f_data,

    // load/store requester
    input  logic          i_d_req,
    input  logic          i_d_we,
    input  logic [AW-1:0] i_d_addr,
    input  logic [DW-1:0] i_d_wdata,
    output logic          o_d_ack,
    output logic [DW-1:0] o_d_rdata,

    // shared RAM port
    output logic [1:0]    o_ram_do,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_val,
    input  logic [DW-1:0] i_ram_val,

    output logic          o_busy
);

    localparam logic [1:0] RAM_NONE  = 2'b00;
    localparam logic [1:0] RAM_READ  = 2'b01;
    localparam logic [1:0] RAM_WRITE = 2'b10;

    // counters sized for the legal parameter ranges (latency 1..4, starve 1..15)
    localparam logic [2:0] LAT_C    = 3'(RAM_LAT);
    localparam logic [3:0] STARVE_C = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;      // 1 = data port owns the transaction
    logic          we_q, we_d;            // latched store flag
    logic [3:0]    starve_q, starve_d;    // consecutive data grants while fetch waits
    logic [2:0]    wait_q, wait_d;        // remaining RAM read latency cycles
    logic [1:0]    ram_do_q, ram_do_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_val_q, ram_val_d;
    logic          f_ack_q, f_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [DW-1:0] f_data_q, f_data_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;

    logic          grant_d;               // arbitration result in IDLE: 1 = data

    // state and output registers; reset drops any in-flight transaction
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            starve_q   <= '0;
            wait_q     <= '0;
            ram_do_q   <= RAM_NONE;
            ram_addr_q <= '0;
            ram_val_q  <= '0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            f_data_q   <= '0;
            d_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            ram_do_q   <= ram_do_d;
            ram_addr_q <= ram_addr_d;
            ram_val_q  <= ram_val_d;
            f_ack_q    <= f_ack_d;
            d_ack_q    <= d_ack_d;
            f_data_q   <= f_data_d;
            d_rdata_q  <= d_rdata_d;
            busy_q     <= busy_d;
        end
    end

    // arbitration: data wins unless fetch has been passed over STARVE_MAX times in a row
    always_comb begin
        grant_d = 1'b0;
        if (i_d_req && !i_f_req) begin
            grant_d = 1'b1;
        end else if (i_d_req && i_f_req && (starve_q < STARVE_C)) begin
            grant_d = 1'b1;
        end
    end

    // next-state logic; every output is computed one cycle ahead so it leaves a flop
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        ram_do_d   = RAM_NONE;
        ram_addr_d = ram_addr_q;
        ram_val_d  = ram_val_q;
        f_ack_d    = 1'b0;
        d_ack_d    = 1'b0;
        f_data_d   = f_data_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (i_f_req || i_d_req) begin
                    owner_d = grant_d;
                    we_d    = grant_d && i_d_we;
                    // only a data grant that bypassed a waiting fetch counts toward starvation
                    if (grant_d && i_f_req) begin
                        starve_d = starve_q + 4'd1;
                    end else begin
                        starve_d = '0;
                    end
                    // command registers go live during ISSUE
                    ram_do_d   = (grant_d && i_d_we) ? RAM_WRITE : RAM_READ;
                    ram_addr_d = grant_d ? i_d_addr : i_f_addr;
                    ram_val_d  = (grant_d && i_d_we) ? i_d_wdata : '0;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (we_q) begin
                    // stores complete without waiting on the RAM
                    d_ack_d = owner_q;
                    f_ack_d = !owner_q;
                    state_d = S_ACK;
                end else begin
                    wait_d  = LAT_C;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                wait_d = wait_q - 3'd1;
                // the counter reads 1 exactly in the cycle the RAM presents read data
                if (wait_q == 3'd1) begin
                    if (owner_q) begin
                        d_rdata_d = i_ram_val;
                    end else begin
                        f_data_d = i_ram_val;
                    end
                    d_ack_d = owner_q;
                    f_ack_d = !owner_q;
                    state_d = S_ACK;
                end
            end

            S_ACK: begin
                // requests are not sampled here so a held req cannot be served twice
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign o_f_ack    = f_ack_q;
    assign o_f_data   = f_data_q;
    assign o_d_ack    = d_ack_q;
    assign o_d_rdata  = d_rdata_q;
    assign o_ram_do   = ram_do_q;
    assign o_ram_addr = ram_addr_q;
    assign o_ram_val  = ram_val_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed self-checking bench for mem_arb
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;

    // DUT with RAM_LAT=1
    logic        f_req, f_ack, d_req, d_we, d_ack, busy;
    logic [31:0] f_addr, f_data, d_addr, d_wdata, d_rdata, ram_addr, ram_wval;
    logic [31:0] ram_rval = 32'hBAD0BAD0;
    logic [1:0]  ram_do;

    // DUT with RAM_LAT=3
    logic        f3_req, f3_ack, d3_req, d3_we, d3_ack, busy3;
    logic [31:0] f3_addr, f3_data, d3_addr, d3_wdata, d3_rdata, ram3_addr, ram3_wval;
    logic [31:0] ram3_rval = 32'hBAD0BAD0;
    logic [1:0]  ram3_do;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int cmd_cnt = 0, fack_cnt = 0, dack_cnt = 0, both_cnt = 0;
    int cmd3_cnt = 0, both3_cnt = 0;
    logic [1:0]  last_do   = 2'b00;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] last_val  = 32'h0;

    int rcnt = 0, rcnt3 = 0;
    logic [31:0] raddr = 32'h0, raddr3 = 32'h0;

    mem_arb #(.AW(32), .DW(32), .RAM_LAT(1), .STARVE_MAX(3)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_ack(f_ack), .o_f_data(f_data),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_ack(d_ack), .o_d_rdata(d_rdata),
        .o_ram_do(ram_do), .o_ram_addr(ram_addr), .o_ram_val(ram_wval), .i_ram_val(ram_rval),
        .o_busy(busy)
    );

    mem_arb #(.AW(32), .DW(32), .RAM_LAT(3), .STARVE_MAX(3)) dut3 (
        .i_clk(clk), .i_rst(rst),
        .i_f_req(f3_req), .i_f_addr(f3_addr), .o_f_ack(f3_ack), .o_f_data(f3_data),
        .i_d_req(d3_req), .i_d_we(d3_we), .i_d_addr(d3_addr), .i_d_wdata(d3_wdata),
        .o_d_ack(d3_ack), .o_d_rdata(d3_rdata),
        .o_ram_do(ram3_do), .o_ram_addr(ram3_addr), .o_ram_val(ram3_wval), .i_ram_val(ram3_rval),
        .o_busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_data(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // RAM models: read data is valid only in cycle ISSUE+latency, junk otherwise
    always @(negedge clk) begin
        ram_rval = 32'hBAD0BAD0;
        if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) ram_rval = ram_data(raddr);
        end
        if (ram_do == 2'b01) begin rcnt = 1; raddr = ram_addr; end
    end

    always @(negedge clk) begin
        ram3_rval = 32'hBAD0BAD0;
        if (rcnt3 > 0) begin
            rcnt3--;
            if (rcnt3 == 0) ram3_rval = ram_data(raddr3);
        end
        if (ram3_do == 2'b01) begin rcnt3 = 3; raddr3 = ram3_addr; end
    end

    // scoreboard of RAM commands and acks
    always @(negedge clk) begin
        if (ram_do != 2'b00) begin
            cmd_cnt++;
            last_do = ram_do; last_addr = ram_addr; last_val = ram_wval;
        end
        if (f_ack) fack_cnt++;
        if (d_ack) dack_cnt++;
        if (f_ack && d_ack) both_cnt++;
        if (ram3_do != 2'b00) cmd3_cnt++;
        if (f3_ack && d3_ack) both3_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // waits for the selected ack; lat counts negedges before the ack cycle
    task automatic wait_ack(input bit sel, input bit dport, output int lat,
                            output int busy_low, output bit to);
        logic ack, bsy;
        lat = 0; busy_low = 0; to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            ack = sel ? (dport ? d3_ack : f3_ack) : (dport ? d_ack : f_ack);
            bsy = sel ? busy3 : busy;
            if (k > 0 && !bsy) busy_low++;
            if (ack) begin to = 1'b0; break; end
            lat++;
        end
    endtask

    initial begin
        int lat, bl, nacks, s_cmd, s_fack, s_dack, s_both, s_cmd3, first_cyc, last_cyc;
        bit to;
        logic [7:0] order;

        rst = 1'b1;
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        f3_req = 0; f3_addr = 0; d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0;
        #3;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ram_do", 32'(ram_do), 32'd0);
        check_val("rst_acks", {30'd0, f_ack, d_ack}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // single fetch
        s_cmd = cmd_cnt; s_dack = dack_cnt;
        f_addr = 32'h10; f_req = 1'b1;
        wait_ack(0, 0, lat, bl, to);
        check_val("fetch_timeout", 32'(to), 32'd0);
        check_val("fetch_latency", 32'(lat), 32'd3);
        check_val("fetch_data", f_data, 32'hDEADBEEF);
        tick(); f_req = 1'b0;
        check_val("fetch_cmds", 32'(cmd_cnt - s_cmd), 32'd1);
        check_val("fetch_do", 32'(last_do), 32'd1);
        check_val("fetch_addr", last_addr, 32'h10);
        check_val("fetch_val", last_val, 32'h0);
        check_val("fetch_no_dack", 32'(dack_cnt - s_dack), 32'd0);
        tick();

        // store
        s_cmd = cmd_cnt;
        d_addr = 32'h40; d_wdata = 32'h12345678; d_we = 1'b1; d_req = 1'b1;
        wait_ack(0, 1, lat, bl, to);
        check_val("store_timeout", 32'(to), 32'd0);
        check_val("store_latency", 32'(lat), 32'd2);
        tick(); d_req = 1'b0; d_we = 1'b0;
        check_val("store_cmds", 32'(cmd_cnt - s_cmd), 32'd1);
        check_val("store_do", 32'(last_do), 32'd2);
        check_val("store_addr", last_addr, 32'h40);
        check_val("store_val", last_val, 32'h12345678);
        check_val("store_rdata_kept", d_rdata, 32'h0);
        check_val("store_fdata_kept", f_data, 32'hDEADBEEF);
        tick();

        // both requesters held: starvation bound
        s_both = both_cnt;
        f_addr = 32'h100; d_addr = 32'h200; f_req = 1'b1; d_req = 1'b1;
        nacks = 0; order = 8'h0; first_cyc = 0; last_cyc = 0;
        for (int k = 0; k < 200 && nacks < 8; k++) begin
            @(negedge clk);
            if (f_ack || d_ack) begin
                order = {order[6:0], d_ack};
                if (nacks == 0) first_cyc = cyc;
                last_cyc = cyc;
                nacks++;
                if (d_ack) check_val("starve_ddata", d_rdata, ram_data(32'h200));
                else       check_val("starve_fdata", f_data, ram_data(32'h100));
            end
        end
        tick(); f_req = 1'b0; d_req = 1'b0;
        check_val("starve_nacks", 32'(nacks), 32'd8);
        check_val("starve_order", 32'(order), 32'hEE);
        check_val("starve_span", 32'(last_cyc - first_cyc), 32'd28);
        check_val("starve_dual_ack", 32'(both_cnt - s_both), 32'd0);
        check_val("starve_read_val", last_val, 32'h0);
        tick();

        // load on the RAM_LAT=3 instance
        s_cmd3 = cmd3_cnt;
        d3_addr = 32'h80; d3_we = 1'b0; d3_req = 1'b1;
        wait_ack(1, 1, lat, bl, to);
        check_val("lat3_timeout", 32'(to), 32'd0);
        check_val("lat3_latency", 32'(lat), 32'd5);
        check_val("lat3_busy_gaps", 32'(bl), 32'd0);
        check_val("lat3_rdata", d3_rdata, ram_data(32'h80));
        tick(); d3_req = 1'b0;
        check_val("lat3_cmds", 32'(cmd3_cnt - s_cmd3), 32'd1);
        tick();

        // async reset during WAIT of a fetch
        s_fack = fack_cnt;
        f_addr = 32'h30; f_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("rstw_issue_do", 32'(ram_do), 32'd1);
        @(negedge clk);
        check_val("rstw_wait_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_val("rstw_busy", 32'(busy), 32'd0);
        check_val("rstw_ram_do", 32'(ram_do), 32'd0);
        check_val("rstw_ram_addr", ram_addr, 32'h0);
        check_val("rstw_fdata", f_data, 32'h0);
        check_val("rstw_drdata", d_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rstw_no_ack", 32'(fack_cnt - s_fack), 32'd0);
        wait_ack(0, 0, lat, bl, to);
        check_val("rstw_timeout", 32'(to), 32'd0);
        check_val("rstw_latency", 32'(lat), 32'd2);
        check_val("rstw_fdata_new", f_data, ram_data(32'h30));
        tick(); f_req = 1'b0;
        tick();
        check_val("rstw_fack_total", 32'(fack_cnt - s_fack), 32'd1);

        // requester holds req one cycle past ack
        s_cmd = cmd_cnt; s_fack = fack_cnt;
        f_addr = 32'h44; f_req = 1'b1;
        wait_ack(0, 0, lat, bl, to);
        check_val("hold_first_timeout", 32'(to), 32'd0);
        check_val("hold_first_latency", 32'(lat), 32'd3);
        tick();
        tick(); f_req = 1'b0;
        wait_ack(0, 0, lat, bl, to);
        check_val("hold_second_timeout", 32'(to), 32'd0);
        check_val("hold_second_latency", 32'(lat), 32'd2);
        tick(); tick();
        check_val("hold_cmds", 32'(cmd_cnt - s_cmd), 32'd2);
        check_val("hold_acks", 32'(fack_cnt - s_fack), 32'd2);
        check_val("hold_fdata", f_data, ram_data(32'h44));

        check_val("total_dual_ack", 32'(both_cnt + both3_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbiter/sequencer that shares the single RAM between the instruction-fetch path (PC side) and the load/store path of proc.
- This removes the separate ROM.
- Each requester uses a req/ack handshake. The block issues one RAM operation at a time, waits out the RAM read latency, and returns the read data with a one-cycle ack.
- Data accesses have priority over fetch, bounded by an anti-starvation counter.

Parameters:
AW  32  address width
DW  32  data width
RAM_LAT  1  cycles from issue cycle to i_ram_val valid (legal 1..4)
STARVE_MAX  3  max consecutive data grants while fetch is pending (legal 1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_f_req  in  1  fetch request; hold until o_f_ack
i_f_addr  in  AW  fetch address; stable while i_f_req
o_f_ack  out  1  one-cycle fetch completion pulse
o_f_data  out  DW  fetch read data; valid when o_f_ack
i_d_req  in  1  data request; hold until o_d_ack
i_d_we  in  1  1=store, 0=load; stable while i_d_req
i_d_addr  in  AW  data address
i_d_wdata  in  DW  store data
o_d_ack  out  1  one-cycle data completion pulse
o_d_rdata  out  DW  load data; valid when o_d_ack and !i_d_we
o_ram_do  out  2  RAM command: RAM_NONE=2'b00, RAM_READ=2'b01, RAM_WRITE=2'b10
o_ram_addr  out  AW  RAM address
o_ram_val  out  DW  RAM write data
i_ram_val  in  DW  RAM read data
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; all outputs 0 (o_ram_do=RAM_NONE); starve counter 0; grant owner cleared.
  - In-flight transaction is dropped with no ack. A requester still holding req after reset release is served fresh.
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - At a clock edge with any req high: latch owner, addr, we and wdata, then go to ISSUE.
  - No req: stay in IDLE.
- Arbitration, sampled in IDLE:
  - Only one requester: grant it.
  - Both requesting and starve_cnt < STARVE_MAX: grant data and increment starve_cnt.
  - Both requesting and starve_cnt == STARVE_MAX: grant fetch and clear starve_cnt.
  - Any grant while i_f_req=0, and any fetch grant: clear starve_cnt.
- ISSUE (exactly 1 cycle):
  - o_ram_do = RAM_WRITE for a store, RAM_READ for a load or fetch.
  - o_ram_addr = latched address; o_ram_val = wdata for a store, else 0.
  - Store: next state ACK. Read: next state WAIT with the wait counter loaded to RAM_LAT.
- Outside ISSUE: o_ram_do = RAM_NONE; o_ram_addr and o_ram_val hold their last values.
- WAIT:
  - Decrement the wait counter each cycle.
  - In the cycle where the counter reads 1, i_ram_val is valid (cycle ISSUE+RAM_LAT). Register it into the owner's rdata output, then go to ACK.
- ACK (exactly 1 cycle):
  - Owner's ack = 1; the other ack stays 0. The next state is always IDLE.
  - Requests are ignored in ACK, so the requester must drop or change req in the cycle after ack.
- Rdata outputs hold their value until the next read completion for that port.
- Latency, req first sampled at edge E0:
  - Read: ack in the cycle after edge E0+RAM_LAT+2.
  - Store: ack in the cycle after edge E0+2.
  - With RAM_LAT=1, a read acks 3 cycles after req and a store 2 cycles after.
- Throughput: back-to-back reads every RAM_LAT+3 cycles; stores every 3 cycles.
- Requests changing mid-transaction (after acceptance) are ignored; latched values are used.
- Never: two acks in the same cycle, more than one RAM command per transaction, or an ack without a prior ISSUE.

Test Plan:
- Reset then single fetch, RAM_LAT=1, addr 0x10, RAM returns 0xDEADBEEF -> o_ram_do=READ for exactly 1 cycle with addr 0x10; o_f_ack 3 cycles after req with o_f_data=0xDEADBEEF; o_d_ack stays 0.
- Store addr 0x40, wdata 0x12345678 -> one RAM_WRITE cycle with o_ram_addr=0x40, o_ram_val=0x12345678; o_d_ack 2 cycles after req; no read data update.
- i_f_req and i_d_req held continuously, STARVE_MAX=3, all reads -> grant order D,D,D,F,D,D,D,F; no two acks coincide.
- RAM_LAT=3 load addr 0x80 -> RAM_READ once, data sampled 3 cycles after ISSUE, o_d_ack 5 cycles after req; o_busy high throughout.
- i_rst asserted asynchronously during WAIT of a fetch -> all outputs 0 immediately, no o_f_ack; after release with i_f_req still high, fetch reissued and acked normally.
- Requester holds req for one extra cycle past ack -> that cycle is ignored (ACK state), a second identical transaction starts only from IDLE; scoreboard counts two RAM commands and two acks.
